// File: rtl/cheshire_rst_seq_pkg.sv
// Shared types and helpers for the Cheshire reset/boot sequencer.
package cheshire_rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD       = 2'd0,
        WAIT_LOCK  = 2'd1,
        REL_PERIPH = 2'd2,
        RUN        = 2'd3
    } rst_seq_state_e;

    typedef enum logic [1:0] {
        POR  = 2'd0,
        BTN  = 2'd1,
        LOCK = 2'd2,
        SW   = 2'd3
    } rst_cause_e;

    // Largest of three cycle counts; sizes the shared state counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Cause recorded on entry to HOLD: lock loss beats button beats software.
    function automatic rst_cause_e cause_of(input logic lock_lost, input logic btn);
        if (lock_lost) return LOCK;
        if (btn)       return BTN;
        return SW;
    endfunction

endpackage

// File: rtl/cheshire_rst_debounce.sv
// 2-FF synchronizer followed by a consecutive-cycle debouncer for the reset button.
module cheshire_rst_debounce
    import cheshire_rst_seq_pkg::*;
#(
    parameter int unsigned Cycles = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_deb
);

    localparam int unsigned CntW = (Cycles > 1) ? $clog2(Cycles) : 1;
    localparam logic [CntW-1:0] Last = CntW'(Cycles - 1);

    logic [1:0]      r_sync;
    logic            r_deb;
    logic [CntW-1:0] r_cnt;

    // Two-stage synchronizer for the asynchronous pushbutton.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
        end
    end

    // Adopt the synchronized value once it has differed for Cycles consecutive cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync[1] == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == Last) begin
            r_deb <= r_sync[1];
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/cheshire_rst_seq.sv
// Reset and boot sequencer: staged peripheral/core reset release, boot-mode latch
// and last-reset-cause recording.
module cheshire_rst_seq
    import cheshire_rst_seq_pkg::*;
#(
    parameter int unsigned DebounceCycles   = 50000,
    parameter int unsigned MinHoldCycles    = 64,
    parameter int unsigned LockStableCycles = 1024,
    parameter int unsigned StageGapCycles   = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btn_rst_i,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    input  logic [1:0] boot_mode_i,
    output logic       periph_rst_no,
    output logic       core_rst_no,
    output logic [1:0] boot_mode_o,
    output logic [1:0] rst_cause_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(max3(MinHoldCycles, LockStableCycles,
                                               StageGapCycles) + 1);
    localparam logic [CntW-1:0] HoldLast = CntW'(MinHoldCycles - 1);
    localparam logic [CntW-1:0] LockLast = CntW'(LockStableCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(StageGapCycles - 1);

    rst_seq_state_e  r_state;
    rst_cause_e      r_cause;
    logic [CntW-1:0] r_cnt;
    logic            r_periph_rst_n;
    logic            r_core_rst_n;
    logic            r_busy;
    logic [1:0]      r_boot_mode;
    logic [1:0]      r_lock_sync;
    logic [1:0]      r_boot_s1;
    logic [1:0]      r_boot_s2;

    logic            w_btn;
    logic            w_lock_lost;
    logic            w_trig;

    cheshire_rst_debounce #(
        .Cycles(DebounceCycles)
    ) u_btn_debounce (
        .i_clk(clk_i),
        .i_rst(rst_i),
        .i_raw(btn_rst_i),
        .o_deb(w_btn)
    );

    // Two-stage synchronizers for the lock flag and the boot switches.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_sync <= '0;
            r_boot_s1   <= '0;
            r_boot_s2   <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_locked_i};
            r_boot_s1   <= boot_mode_i;
            r_boot_s2   <= r_boot_s1;
        end
    end

    assign w_lock_lost = ~r_lock_sync[1];
    assign w_trig      = w_lock_lost | w_btn | sw_rst_req_i;

    // Sequencer FSM with registered reset, busy, boot-mode and cause outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= HOLD;
            r_cause        <= POR;
            r_cnt          <= '0;
            r_periph_rst_n <= 1'b0;
            r_core_rst_n   <= 1'b0;
            r_busy         <= 1'b1;
            r_boot_mode    <= '0;
        end else begin
            unique case (r_state)
                HOLD: begin
                    // Counter saturates so a long request still leaves on its first free cycle.
                    if (r_cnt >= HoldLast && !w_btn && !sw_rst_req_i) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt < HoldLast) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (w_btn || sw_rst_req_i) begin
                        r_state <= HOLD;
                        r_cnt   <= '0;
                        r_cause <= cause_of(1'b0, w_btn);
                    end else if (w_lock_lost) begin
                        r_cnt <= '0;
                    end else if (r_cnt == LockLast) begin
                        r_state        <= REL_PERIPH;
                        r_cnt          <= '0;
                        r_periph_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                REL_PERIPH: begin
                    if (w_trig) begin
                        r_state        <= HOLD;
                        r_cnt          <= '0;
                        r_periph_rst_n <= 1'b0;
                        r_cause        <= cause_of(w_lock_lost, w_btn);
                    end else if (r_cnt == GapLast) begin
                        r_state      <= RUN;
                        r_cnt        <= '0;
                        r_core_rst_n <= 1'b1;
                        r_busy       <= 1'b0;
                        r_boot_mode  <= r_boot_s2;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                RUN: begin
                    if (w_trig) begin
                        r_state        <= HOLD;
                        r_cnt          <= '0;
                        r_periph_rst_n <= 1'b0;
                        r_core_rst_n   <= 1'b0;
                        r_busy         <= 1'b1;
                        r_cause        <= cause_of(w_lock_lost, w_btn);
                    end
                end
                default: begin
                    r_state <= HOLD;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign periph_rst_no = r_periph_rst_n;
    assign core_rst_no   = r_core_rst_n;
    assign busy_o        = r_busy;
    assign boot_mode_o   = r_boot_mode;
    assign rst_cause_o   = r_cause;

endmodule

// File: tb/tb_cheshire_rst_seq.sv
// Self-checking bench for cheshire_rst_seq: directed scenarios plus a random phase,
// all compared every cycle against a behavioural model.
module tb_cheshire_rst_seq;

    localparam int DEB = 4;
    localparam int MH  = 4;
    localparam int LS  = 8;
    localparam int SG  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       lock;
    logic       sw;
    logic [1:0] boot;
    logic       periph_rst_no;
    logic       core_rst_no;
    logic [1:0] boot_mode_o;
    logic [1:0] rst_cause_o;
    logic       busy_o;

    cheshire_rst_seq #(
        .DebounceCycles(DEB),
        .MinHoldCycles(MH),
        .LockStableCycles(LS),
        .StageGapCycles(SG)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .btn_rst_i(btn),
        .pll_locked_i(lock),
        .sw_rst_req_i(sw),
        .boot_mode_i(boot),
        .periph_rst_no(periph_rst_no),
        .core_rst_no(core_rst_no),
        .boot_mode_o(boot_mode_o),
        .rst_cause_o(rst_cause_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    // Behavioural model: phase 0 hold, 1 wait lock, 2 peripheral released, 3 running.
    int         m_phase;
    int         m_elapsed;
    int         m_run;
    logic       m_deb;
    logic [1:0] m_btn_h;
    logic [1:0] m_lock_h;
    logic [1:0] m_boot_h0;
    logic [1:0] m_boot_h1;
    logic [1:0] m_boot;
    logic [1:0] m_cause;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_run     = 0;
        m_deb     = 1'b0;
        m_btn_h   = '0;
        m_lock_h  = '0;
        m_boot_h0 = '0;
        m_boot_h1 = '0;
        m_boot    = '0;
        m_cause   = 2'd0;
    endtask

    task automatic enter_hold(input logic lost, input logic b);
        m_phase   = 0;
        m_elapsed = 0;
        m_cause   = lost ? 2'd2 : (b ? 2'd1 : 2'd3);
    endtask

    task automatic model_step();
        logic lock_seen;
        logic btn_seen;
        if (rst) begin
            model_reset();
            return;
        end
        lock_seen = m_lock_h[1];
        btn_seen  = m_deb;
        case (m_phase)
            0: begin
                m_elapsed++;
                if (m_elapsed >= MH && !btn_seen && !sw) begin
                    m_phase   = 1;
                    m_elapsed = 0;
                end
            end
            1: begin
                if (btn_seen || sw) enter_hold(1'b0, btn_seen);
                else if (lock_seen) begin
                    m_elapsed++;
                    if (m_elapsed == LS) begin
                        m_phase   = 2;
                        m_elapsed = 0;
                    end
                end else m_elapsed = 0;
            end
            2: begin
                if (!lock_seen || btn_seen || sw) enter_hold(!lock_seen, btn_seen);
                else begin
                    m_elapsed++;
                    if (m_elapsed == SG) begin
                        m_phase   = 3;
                        m_elapsed = 0;
                        m_boot    = m_boot_h1;
                    end
                end
            end
            default: begin
                if (!lock_seen || btn_seen || sw) enter_hold(!lock_seen, btn_seen);
            end
        endcase
        if (m_btn_h[1] != m_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = m_btn_h[1];
                m_run = 0;
            end
        end else m_run = 0;
        m_btn_h   = {m_btn_h[0], btn};
        m_lock_h  = {m_lock_h[0], lock};
        m_boot_h1 = m_boot_h0;
        m_boot_h0 = boot;
    endtask

    task automatic compare_all();
        check("periph_rst_no", int'(periph_rst_no), (m_phase >= 2) ? 1 : 0);
        check("core_rst_no", int'(core_rst_no), (m_phase == 3) ? 1 : 0);
        check("busy_o", int'(busy_o), (m_phase == 3) ? 0 : 1);
        check("boot_mode_o", int'(boot_mode_o), int'(m_boot));
        check("rst_cause_o", int'(rst_cause_o), int'(m_cause));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        edge_cnt++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_core_high(input string tag, input int budget);
        for (int i = 0; i < budget && !core_rst_no; i++) tick();
        check(tag, int'(core_rst_no), 1);
    endtask

    task automatic wait_periph_high(output int n, input int budget);
        n = 0;
        for (int i = 1; i <= budget && n == 0; i++) begin
            tick();
            if (periph_rst_no) n = i;
        end
    endtask

    initial begin
        int pe;
        int ce;
        int n;
        model_reset();
        rst  = 1'b1;
        btn  = 1'b0;
        lock = 1'b1;
        sw   = 1'b0;
        boot = 2'b10;
        repeat (3) tick();
        check("reset_periph", int'(periph_rst_no), 0);
        check("reset_core", int'(core_rst_no), 0);
        check("reset_busy", int'(busy_o), 1);
        check("reset_cause", int'(rst_cause_o), 0);
        rst      = 1'b0;
        edge_cnt = 0;

        // Power-on sequence with lock already high.
        pe = 0;
        ce = 0;
        for (int i = 0; i < 40 && ce == 0; i++) begin
            tick();
            if (pe == 0 && periph_rst_no) pe = edge_cnt;
            if (core_rst_no) ce = edge_cnt;
        end
        check("por_periph_edge", pe, MH + LS);
        check("por_core_edge", ce, MH + LS + SG);
        check("por_boot_mode", int'(boot_mode_o), 2);
        check("por_cause", int'(rst_cause_o), 0);
        check("por_busy", int'(busy_o), 0);

        // Short button pulse is filtered out.
        boot = 2'b01;
        btn  = 1'b1;
        repeat (3) tick();
        btn = 1'b0;
        repeat (12) tick();
        check("btn_short_core", int'(core_rst_no), 1);

        // Long button pulse resets after sync + debounce + register latency.
        n   = 0;
        btn = 1'b1;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            tick();
            if (i == 6) btn = 1'b0;
            if (!core_rst_no) n = i;
        end
        btn = 1'b0;
        check("btn_long_latency", n, 2 + DEB + 1);
        check("btn_cause", int'(rst_cause_o), 1);
        wait_core_high("btn_replay", 80);
        check("btn_replay_boot", int'(boot_mode_o), 1);

        // One-cycle lock drop in RUN.
        n    = 0;
        lock = 1'b0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            tick();
            if (i == 1) lock = 1'b1;
            if (!core_rst_no) n = i;
        end
        check("lock_loss_latency", n, 3);
        check("lock_cause", int'(rst_cause_o), 2);
        // Lock chatter in WAIT_LOCK never completes a stable window.
        for (int i = 0; i < 36; i++) begin
            lock = ((i % 6) == 5) ? 1'b0 : 1'b1;
            tick();
        end
        check("lock_toggle_periph", int'(periph_rst_no), 0);
        check("lock_toggle_cause", int'(rst_cause_o), 2);
        lock = 1'b1;
        wait_core_high("lock_replay", 60);

        // Software request held for 20 cycles.
        n  = 0;
        sw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (n == 0 && !core_rst_no) n = i;
        end
        sw = 1'b0;
        check("sw_latency", n, 1);
        check("sw_cause", int'(rst_cause_o), 3);
        wait_periph_high(n, 40);
        check("sw_release_periph", n, 1 + LS);

        // Lock loss and software request reach the sequencer together in REL_PERIPH.
        lock = 1'b0;
        tick();
        tick();
        sw = 1'b1;
        tick();
        check("dual_periph", int'(periph_rst_no), 0);
        check("dual_cause", int'(rst_cause_o), 2);
        sw   = 1'b0;
        lock = 1'b1;
        wait_core_high("dual_replay", 60);

        // Block reset in the middle of REL_PERIPH.
        sw = 1'b1;
        tick();
        sw = 1'b0;
        wait_periph_high(n, 40);
        check("rstpulse_reach_rel", n == 0 ? 0 : 1, 1);
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rstpulse_cause", int'(rst_cause_o), 0);
        check("rstpulse_periph", int'(periph_rst_no), 0);
        repeat (2) tick();
        rst = 1'b0;
        wait_core_high("rstpulse_replay", 60);

        // Random phase: sparse button, lock and request activity.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) < 2) btn = ~btn;
            if (lock && $urandom_range(0, 99) < 2) lock = 1'b0;
            else if (!lock && $urandom_range(0, 99) < 40) lock = 1'b1;
            if (!sw && $urandom_range(0, 199) < 2) sw = 1'b1;
            else if (sw && $urandom_range(0, 99) < 20) sw = 1'b0;
            if ($urandom_range(0, 99) < 5) boot = 2'($urandom_range(0, 3));
            tick();
        end
        btn  = 1'b0;
        lock = 1'b1;
        sw   = 1'b0;
        wait_core_high("random_final_release", 80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
